// File: rtl/timer_arbiter.sv
// One shared countdown timer. Requesters latch into sticky pending flags and are
// granted round-robin; the running effect can be restarted, paused or cancelled.
module timer_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     count_clk,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] dur,
   input  logic                     pause,
   input  logic                     cancel,
   output logic                     enable,
   output logic [NUM_REQ-1:0]       active,
   output logic [CNT_W-1:0]         remaining,
   output logic [NUM_REQ-1:0]       pending,
   output logic                     done,
   output logic [NUM_REQ-1:0]       done_id
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               r_state;
   logic                 r_enable;
   logic [NUM_REQ-1:0]   r_active;
   logic [CNT_W-1:0]     r_remaining;
   logic [NUM_REQ-1:0]   r_pending;
   logic                 r_done;
   logic [NUM_REQ-1:0]   r_done_id;
   logic [IDX_W-1:0]     r_last;

   logic [CNT_W-1:0]     w_dur [NUM_REQ];
   logic                 w_gnt_vld;
   logic [IDX_W-1:0]     w_gnt_idx;
   logic [NUM_REQ-1:0]   w_gnt_oh;
   logic [IDX_W:0]       w_sum;

   // A zero duration still runs for one tick.
   function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] d);
      return (d == '0) ? CNT_W'(1) : d;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) w_dur[i] = dur[i*CNT_W +: CNT_W];
   end

   // Round-robin search starting one past the last grant, wrapping at NUM_REQ-1.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_sum     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
         if (!w_gnt_vld && r_pending[w_sum[IDX_W-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_sum[IDX_W-1:0];
         end
      end
      w_gnt_oh            = '0;
      w_gnt_oh[w_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_enable    <= 1'b0;
         r_active    <= '0;
         r_remaining <= '0;
         r_pending   <= '0;
         r_done      <= 1'b0;
         r_done_id   <= '0;
         r_last      <= IDX_W'(NUM_REQ-1);
      end else if (cancel) begin
         // Abort without a done pulse; the round-robin pointer survives.
         r_state     <= S_IDLE;
         r_enable    <= 1'b0;
         r_active    <= '0;
         r_remaining <= '0;
         r_pending   <= '0;
         r_done      <= 1'b0;
         r_done_id   <= '0;
      end else begin
         r_done    <= 1'b0;
         r_done_id <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_state     <= S_RUN;
                  r_enable    <= 1'b1;
                  r_active    <= w_gnt_oh;
                  r_remaining <= f_load(w_dur[w_gnt_idx]);
                  r_pending   <= (r_pending | req) & ~w_gnt_oh;
                  r_last      <= w_gnt_idx;
               end else begin
                  r_pending <= r_pending | req;
               end
            end
            S_RUN: begin
               r_pending <= r_pending | (req & ~r_active);
               // r_last always names the running requester here.
               if (|(req & r_active)) begin
                  r_remaining <= f_load(w_dur[r_last]);
               end else if (count_clk && !pause) begin
                  if (r_remaining <= CNT_W'(1)) begin
                     r_state     <= S_DONE;
                     r_enable    <= 1'b0;
                     r_active    <= '0;
                     r_remaining <= '0;
                     r_done      <= 1'b1;
                     r_done_id   <= r_active;
                  end else begin
                     r_remaining <= r_remaining - CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_pending <= r_pending | req;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign enable    = r_enable;
   assign active    = r_active;
   assign remaining = r_remaining;
   assign pending   = r_pending;
   assign done      = r_done;
   assign done_id   = r_done_id;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: basic run, round-robin, restart, pause,
// cancel/reset and edge durations, with hand-computed expectations.
module tb_timer_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        count_clk;
   logic [3:0]  req;
   logic [15:0] dur;
   logic        pause;
   logic        cancel;
   logic        enable;
   logic [3:0]  active;
   logic [3:0]  remaining;
   logic [3:0]  pending;
   logic        done;
   logic [3:0]  done_id;

   int n_tests = 0;
   int n_fail  = 0;

   timer_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .count_clk(count_clk), .req(req), .dur(dur),
      .pause(pause), .cancel(cancel), .enable(enable), .active(active),
      .remaining(remaining), .pending(pending), .done(done), .done_id(done_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      count_clk = 1'b1;
      step();
      count_clk = 1'b0;
   endtask

   task automatic pulse_req(input logic [3:0] r);
      req = r;
      step();
      req = '0;
   endtask

   initial begin
      reset = 1'b0; count_clk = 1'b0; req = '0; dur = '0; pause = 1'b0; cancel = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst_enable", 32'(enable), 0);
      chk("rst_active", 32'(active), 0);
      chk("rst_remaining", 32'(remaining), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_done_id", 32'(done_id), 0);
      #9 reset = 1'b0;

      // Basic run, ticks spaced 5 clocks apart
      dur = 16'h0030;
      pulse_req(4'b0010);
      chk("basic_pending", 32'(pending), 32'h2);
      chk("basic_no_grant_yet", 32'(active), 0);
      step();
      chk("basic_active", 32'(active), 32'h2);
      chk("basic_enable", 32'(enable), 1);
      chk("basic_rem3", 32'(remaining), 3);
      chk("basic_pend_clr", 32'(pending), 0);
      repeat (4) step();
      tick();
      chk("basic_rem2", 32'(remaining), 2);
      repeat (4) step();
      tick();
      chk("basic_rem1", 32'(remaining), 1);
      repeat (4) step();
      tick();
      chk("basic_done", 32'(done), 1);
      chk("basic_done_id", 32'(done_id), 32'h2);
      chk("basic_rem0", 32'(remaining), 0);
      chk("basic_act_clr", 32'(active), 0);
      chk("basic_en_clr", 32'(enable), 0);
      step();
      chk("basic_done_1cyc", 32'(done), 0);
      chk("basic_done_id_clr", 32'(done_id), 0);

      // Round-robin from a fresh pointer
      reset = 1'b1; #1 reset = 1'b0;
      dur = 16'h1111;
      pulse_req(4'b1011);
      chk("rr_pending", 32'(pending), 32'hB);
      step();
      chk("rr_g0", 32'(active), 32'h1);
      chk("rr_pend_after_g0", 32'(pending), 32'hA);
      tick();
      chk("rr_done0", 32'(done_id), 32'h1);
      step();
      chk("rr_idle_gap", 32'(active), 0);
      step();
      chk("rr_g1", 32'(active), 32'h2);
      tick();
      chk("rr_done1", 32'(done_id), 32'h2);
      step();
      step();
      chk("rr_g3", 32'(active), 32'h8);
      chk("rr_pend_empty", 32'(pending), 0);
      tick();
      chk("rr_done3", 32'(done_id), 32'h8);
      pulse_req(4'b1001);
      chk("rr_pend_in_done", 32'(pending), 32'h9);
      step();
      chk("rr_wrap_g0", 32'(active), 32'h1);
      chk("rr_wrap_pend", 32'(pending), 32'h8);
      tick();
      step();
      step();
      chk("rr_then_g3", 32'(active), 32'h8);
      tick();
      step();

      // Restart on own req, same cycle as a tick
      dur = 16'h0400;
      pulse_req(4'b0100);
      step();
      chk("rs_active", 32'(active), 32'h4);
      chk("rs_rem4", 32'(remaining), 4);
      tick();
      tick();
      chk("rs_rem2", 32'(remaining), 2);
      count_clk = 1'b1; req = 4'b0100;
      step();
      count_clk = 1'b0; req = '0;
      chk("rs_reload", 32'(remaining), 4);
      chk("rs_no_done", 32'(done), 0);
      chk("rs_no_pend", 32'(pending), 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("rs_count", 32'(remaining), 32'(4 - i));
         chk("rs_not_done", 32'(done), 0);
      end
      tick();
      chk("rs_done", 32'(done), 1);
      chk("rs_done_id", 32'(done_id), 32'h4);
      step();

      // Pause: grant still happens, countdown frozen
      pause = 1'b1;
      pulse_req(4'b0100);
      step();
      chk("pz_grant", 32'(active), 32'h4);
      tick();
      chk("pz_hold_load", 32'(remaining), 4);
      pause = 1'b0;
      tick();
      tick();
      chk("pz_rem2", 32'(remaining), 2);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pz_rem_hold", 32'(remaining), 2);
         chk("pz_en_hold", 32'(enable), 1);
      end
      chk("pz_act_hold", 32'(active), 32'h4);
      pause = 1'b0;
      tick();
      chk("pz_rem1", 32'(remaining), 1);
      chk("pz_not_done", 32'(done), 0);
      tick();
      chk("pz_done", 32'(done), 1);
      step();

      // Cancel beats a simultaneous req
      dur = 16'h0440;
      pulse_req(4'b0010);
      step();
      chk("cn_active", 32'(active), 32'h2);
      pulse_req(4'b0100);
      chk("cn_pending", 32'(pending), 32'h4);
      tick();
      chk("cn_rem3", 32'(remaining), 3);
      cancel = 1'b1; req = 4'b0001;
      step();
      cancel = 1'b0; req = '0;
      chk("cn_active_clr", 32'(active), 0);
      chk("cn_pend_clr", 32'(pending), 0);
      chk("cn_en_clr", 32'(enable), 0);
      chk("cn_rem_clr", 32'(remaining), 0);
      chk("cn_no_done", 32'(done), 0);
      step();
      chk("cn_stay_idle", 32'(active), 0);
      chk("cn_no_done2", 32'(done), 0);

      // Same scenario, reset between clock edges
      pulse_req(4'b0010);
      step();
      chk("ar_active", 32'(active), 32'h2);
      pulse_req(4'b0100);
      chk("ar_pending", 32'(pending), 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("ar_act_async", 32'(active), 0);
      chk("ar_pend_async", 32'(pending), 0);
      chk("ar_en_async", 32'(enable), 0);
      chk("ar_rem_async", 32'(remaining), 0);
      chk("ar_done_async", 32'(done), 0);
      #1 reset = 1'b0;
      step();
      chk("ar_idle", 32'(active), 0);
      chk("ar_no_done", 32'(done), 0);

      // Edge durations: 0 acts as 1, 15 runs full length
      dur = 16'h00F0;
      pulse_req(4'b0001);
      step();
      chk("d0_active", 32'(active), 32'h1);
      chk("d0_load1", 32'(remaining), 1);
      tick();
      chk("d0_done", 32'(done), 1);
      chk("d0_done_id", 32'(done_id), 32'h1);
      step();
      pulse_req(4'b0010);
      step();
      chk("d15_load", 32'(remaining), 15);
      for (int i = 1; i <= 14; i++) begin
         tick();
         chk("d15_count", 32'(remaining), 32'(15 - i));
      end
      chk("d15_not_done", 32'(done), 0);
      tick();
      chk("d15_done", 32'(done), 1);
      chk("d15_rem0", 32'(remaining), 0);
      chk("d15_done_id", 32'(done_id), 32'h2);
      tick();
      chk("d15_no_wrap", 32'(remaining), 0);
      chk("d15_done_1cyc", 32'(done), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
